frozen_set_manager: RTL

Runtime-reconfigurable frozen-bit store for the SC-family polar decoders. It holds `NUM_CFG` independent frozen masks of length N = 2^`N_LOG`. Each mask is loaded word-by-word through a valid/ready handshake and committed atomically. The decoder's bit-index sequencer queries it with a registered, one-cycle-latency frozen indication. It also reports the information-bit count K of the active mask, so rate checks need no extra logic.

---
 rtl/polar_pkg.sv | 35 +++
 rtl/frozen_set_manager_popcount_tree.sv | 43 ++++
 rtl/frozen_set_manager.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/polar_pkg.sv
// -----------------------------------------------------------------------------
// polar_pkg
//   Shared definitions for the SC-family polar decoder blocks.
//   - load_state_t : frozen-mask loader FSM states (IDLE / LOAD / COMMIT)
//   - FROZEN       : polarity of a frozen bit in a mask (1 = frozen)
//   - cfg_width()  : select width for a bank of NUM_CFG masks, never below 1
//   - words_per_mask() / count_width() / index_width() : loader geometry
// -----------------------------------------------------------------------------
package polar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } load_state_t;

    localparam logic FROZEN = 1'b1;

    function automatic int cfg_width(input int num_cfg);
        return (num_cfg > 1) ? $clog2(num_cfg) : 1;
    endfunction

    function automatic int words_per_mask(input int n_log, input int load_w);
        return (1 << n_log) / load_w;
    endfunction

    function automatic int count_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic int index_width(input int n_log);
        return (n_log > 0) ? n_log : 1;
    endfunction

endpackage

// File: rtl/frozen_set_manager_popcount_tree.sv
// -----------------------------------------------------------------------------
// popcount_tree
//   Purely combinational population count, built as a balanced binary tree by
//   recursively splitting the input in halves.
//   Ports:
//     bits  [WIDTH-1:0] in  : vector to count
//     count [CNT_W-1:0] out : number of ones in bits
// -----------------------------------------------------------------------------
module popcount_tree #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] count
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = CNT_W'(bits);
        end else begin : g_split
            localparam int LO_W  = WIDTH / 2;
            localparam int HI_W  = WIDTH - LO_W;
            localparam int LO_CW = $clog2(LO_W + 1);
            localparam int HI_CW = $clog2(HI_W + 1);

            logic [LO_CW-1:0] lo_cnt;
            logic [HI_CW-1:0] hi_cnt;

            popcount_tree #(.WIDTH(LO_W), .CNT_W(LO_CW)) u_lo (
                .bits  (bits[LO_W-1:0]),
                .count (lo_cnt)
            );

            popcount_tree #(.WIDTH(HI_W), .CNT_W(HI_CW)) u_hi (
                .bits  (bits[WIDTH-1:LO_W]),
                .count (hi_cnt)
            );

            assign count = CNT_W'(lo_cnt) + CNT_W'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/frozen_set_manager.sv
// -----------------------------------------------------------------------------
// frozen_set_manager
//   Bank of NUM_CFG frozen-bit masks (N = 2^N_LOG bits each, 1 = frozen).
//   Masks are loaded word-by-word into a shadow register and copied into the
//   target mask in a single COMMIT cycle, so a stored mask is never seen
//   half-written. Queries return the selected mask bit one cycle later, and
//   k_count tracks the number of information (zero) bits of the active mask.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     cfg_sel   [CW-1:0]    : active mask for queries and k_count
//     q_valid, q_index      : query strobe and bit index
//     q_frozen, q_rvalid    : registered query result / delayed strobe
//     ld_start, ld_cfg      : begin a load into mask ld_cfg
//     ld_valid, ld_data     : load word handshake (with ld_ready)
//     ld_ready              : high in LOAD
//     ld_done               : one-cycle pulse in COMMIT
//     busy                  : high in LOAD and COMMIT
//     k_count   [N_LOG:0]   : N - popcount(active mask), registered
// -----------------------------------------------------------------------------
module frozen_set_manager
    import polar_pkg::*;
#(
    parameter int                    N_LOG      = 3,
    parameter int                    LOAD_W     = 8,
    parameter int                    NUM_CFG    = 2,
    parameter logic [(1<<N_LOG)-1:0] RESET_MASK = '1,
    localparam int                   CW         = cfg_width(NUM_CFG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW-1:0]     cfg_sel,
    input  logic              q_valid,
    input  logic [N_LOG-1:0]  q_index,
    output logic              q_frozen,
    output logic              q_rvalid,
    input  logic              ld_start,
    input  logic [CW-1:0]     ld_cfg,
    input  logic              ld_valid,
    input  logic [LOAD_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
    output logic [N_LOG:0]    k_count
);

    localparam int N   = 1 << N_LOG;
    localparam int W   = words_per_mask(N_LOG, LOAD_W);
    localparam int WCW = count_width(W);
    localparam int KW  = N_LOG + 1;

    function automatic int ones_in(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

    localparam logic [KW-1:0] K_RESET = KW'(N - ones_in(RESET_MASK));

    load_state_t       state_reg;
    load_state_t       state_next;
    logic [WCW-1:0]    wc_reg;
    logic [CW-1:0]     cfg_reg;
    logic [N-1:0]      shadow_reg;
    logic [N-1:0]      mask_reg [NUM_CFG];
    logic [NUM_CFG-1:0] commit_hit;
    logic [N-1:0]      sel_mask;
    logic [KW-1:0]     sel_ones;
    logic              ld_fire;
    logic              last_word;

    assign ld_fire   = ld_valid && ld_ready;
    assign last_word = (wc_reg == WCW'(W - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (ld_start) state_next = ST_LOAD;
            ST_LOAD:   if (ld_fire && last_word) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        busy     = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                ld_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_COMMIT: begin
                ld_done = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- Loader datapath: word counter, target, shadow ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_reg     <= '0;
            cfg_reg    <= '0;
            shadow_reg <= RESET_MASK;
        end else begin
            if (state_reg == ST_IDLE && ld_start) begin
                cfg_reg <= ld_cfg;
                wc_reg  <= '0;
            end
            if (ld_fire) begin
                // Word k lands on bit indices k*LOAD_W .. k*LOAD_W+LOAD_W-1.
                for (int i = 0; i < W; i++) begin
                    if (wc_reg == WCW'(i)) begin
                        shadow_reg[i*LOAD_W +: LOAD_W] <= ld_data;
                    end
                end
                wc_reg <= wc_reg + WCW'(1);
            end
        end
    end

    // ---------------- Mask bank ----------------
    // An out-of-range target matches no entry, so such a load is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CFG; gi++) begin : g_hit
            assign commit_hit[gi] = (state_reg == ST_COMMIT) && (cfg_reg == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                mask_reg[i] <= RESET_MASK;
            end
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (commit_hit[i]) begin
                    mask_reg[i] <= shadow_reg;
                end
            end
        end
    end

    // Active mask; an unpopulated selector value reads as fully frozen.
    always_comb begin
        sel_mask = {N{FROZEN}};
        for (int i = 0; i < NUM_CFG; i++) begin
            if (cfg_sel == CW'(i)) begin
                sel_mask = mask_reg[i];
            end
        end
    end

    popcount_tree #(.WIDTH(N), .CNT_W(KW)) u_popcount (
        .bits  (sel_mask),
        .count (sel_ones)
    );

    // ---------------- Query and rate registers ----------------
    // Reads see the pre-commit mask during COMMIT because the bank updates
    // on the same edge that samples the query.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_frozen <= FROZEN;
            q_rvalid <= 1'b0;
            k_count  <= K_RESET;
        end else begin
            q_frozen <= q_valid ? sel_mask[q_index] : FROZEN;
            q_rvalid <= q_valid;
            k_count  <= KW'(N) - sel_ones;
        end
    end

endmodule
